weight_bram_reader: RTL and testbench
=====================================

# weight_bram_reader

Read-side sequencer for a single-port 16-bit weight BRAM holding one neuron's weight column (default 28 words). On a START pulse it walks the BRAM from address 0 to DEPTH-1 and streams each weight to the downstream MAC over a valid/ready interface. It absorbs downstream back-pressure without losing or duplicating words. It sits between each weight BRAM and its multiply-accumulate lane in the ANN datapath.

## Interface
- DEPTH, 28, number of weight words per pass
- AW, 5, BRAM address width
- DW, 16, weight word width
- CLK  in  1  system clock; BRAM samples on negedge, this block on posedge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; begins a pass; ignored unless idle
- BRAM_ADDR  out  AW  read address to BRAM
- BRAM_EN  out  1  BRAM enable; high only for cycles issuing a read
- BRAM_WE  out  1  constant 0; this block never writes
- BRAM_DO  in  DW  BRAM read data
- W_DATA  out  DW  weight word to MAC
- W_VALID  out  1  W_DATA holds a valid word
- W_READY  in  1  MAC accepts the word; transfer when W_VALID && W_READY at posedge
- W_LAST  out  1  qualifies the word from address DEPTH-1
- BUSY  out  1  high whenever state != IDLE
- DONE  out  1  one-cycle pulse after the last word transfers
- CHECKSUM  out  DW  only with WEIGHT_READER_CHECKSUM_EN; see Configuration

## Operation
- FSM states:
  - IDLE: START=1 -> RUN, read address cleared to 0.
  - RUN: issues reads; after the read of DEPTH-1 is issued -> FLUSH.
  - FLUSH: no new reads; when the W_LAST word transfers -> DONE.
  - DONE: DONE=1 for one cycle -> IDLE.
- Read issue:
  - BRAM_EN is registered and pulses high for exactly one cycle per read, with BRAM_ADDR = next address. The address increments by 1 per issued read and never wraps within a pass.
  - Read data returns at the following negedge and is captured at the next posedge into a 2-entry output FIFO.
- Credit rule: let count = FIFO occupancy + reads in flight (0 or 1) − (1 if a transfer occurs this cycle). A read is issued for the next cycle only if in RUN and count < 2. The FIFO therefore never overflows.
- Output:
  - W_DATA/W_LAST come from the FIFO head; W_VALID = FIFO not empty.
  - While W_VALID && !W_READY, W_DATA and W_LAST stay stable.
- W_LAST travels with the data word for the final address: one tag bit per FIFO entry.
- START while BUSY is ignored. START in the DONE cycle is also ignored.
- Reset values (async, immediate): state IDLE, BRAM_ADDR 0, BRAM_EN 0, BRAM_WE 0, W_DATA 0, W_VALID 0, W_LAST 0, BUSY 0, DONE 0, CHECKSUM 0, FIFO empty, in-flight cleared.
- RST mid-pass abandons the pass. The next START restarts at address 0 with no stale words emitted.

## Timing
- Edge E0 samples START=1 in IDLE.
  - Cycle 1: BUSY=1, BRAM_EN=1, BRAM_ADDR=0.
  - Cycle 2: W_VALID=1 with word 0.
- W_READY held high: one word per cycle. Word k is presented in cycle 2+k. W_LAST is high in cycle DEPTH+1 (29). DONE=1 in cycle DEPTH+2 (30). BUSY is 1 in cycles 1..30 and 0 in cycle 31.
- Back-pressure: at most 2 reads are outstanding (FIFO occupancy plus in flight). When W_READY is low long enough, BRAM_EN stops within 2 cycles. Issue resumes the cycle after the first transfer frees a credit.
- DEPTH=1: single word carries W_LAST, and the FSM goes RUN -> FLUSH after one issue.

## Configuration
- WEIGHT_READER_CHECKSUM_EN defined:
  - CHECKSUM port exists: a DW-bit wrap-around sum (modulo 2^DW) of every transferred W_DATA in the current pass.
  - It is cleared on START acceptance and holds its value from DONE until the next START.
- Not defined: the CHECKSUM port and its adder are absent; all other behaviour is identical.

## Test plan
- Reset: assert RST mid-cycle with no clock edge -> all outputs 0 immediately; BRAM_WE stays 0 throughout the sim.
- BRAM model preloaded with mem[i]=16'h0100+i, W_READY=1, START pulse -> W_DATA 0x0100..0x011B in cycles 2..29, W_LAST only on 0x011B, DONE in cycle 30, BUSY low in cycle 31.
- W_READY alternating 1/0 -> all 28 words in order with no duplicates; W_DATA stable during stalls; BRAM_EN never asserted with count ≥ 2.
- W_READY low for 10 cycles after word 0 appears -> exactly 2 reads are issued; when ready returns, 0x0101 follows 0x0100 with no gap beyond one cycle.
- RST during word 10, then START again -> stream restarts at 0x0100; no word from the aborted pass appears; START pulses during BUSY are ignored.
- WEIGHT_READER_CHECKSUM_EN defined, full pass -> CHECKSUM = 0x1D7A at DONE, cleared to 0 on the next START.

Source files
------------

// File: rtl/weight_bram_reader.sv
// Read sequencer for one weight BRAM column: walks addresses 0..DEPTH-1 and streams
// each word over valid/ready. Optional CHECKSUM port under WEIGHT_READER_CHECKSUM_EN.
module weight_bram_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic [AW-1:0] BRAM_ADDR,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE
`ifdef WEIGHT_READER_CHECKSUM_EN
   ,output logic [DW-1:0] CHECKSUM
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH-1);

    state_t               state, state_nx;
    logic [AW:0]          next_addr;
    logic [1:0][DW-1:0]   fifo_data;
    logic [1:0]           fifo_last;
    logic                 rd_ptr, wr_ptr;
    logic [1:0]           occ;
    logic [2:0]           credit;
    logic                 xfer, issue, start_acc;

    assign BRAM_WE   = 1'b0;
    assign xfer      = W_VALID && W_READY;
    assign start_acc = (state == S_IDLE) && START;
    // BRAM_EN marks the one read in flight; its data lands in the FIFO at the next posedge.
    assign credit    = {1'b0, occ} + {2'b0, BRAM_EN} - {2'b0, xfer};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (START) state_nx = S_RUN;
            S_RUN:   if (next_addr == DEPTH_C) state_nx = S_FLUSH;
            S_FLUSH: if (xfer && W_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The first read is issued on the START edge so data appears two cycles later.
    always_comb begin
        BUSY  = (state != S_IDLE);
        DONE  = (state == S_DONE);
        issue = start_acc ||
                ((state == S_RUN) && (next_addr < DEPTH_C) && (credit < 3'd2));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BRAM_EN   <= 1'b0;
            BRAM_ADDR <= '0;
            next_addr <= '0;
        end else begin
            BRAM_EN <= issue;
            if (issue) begin
                if (start_acc) begin
                    BRAM_ADDR <= '0;
                    next_addr <= (AW+1)'(1);
                end else begin
                    BRAM_ADDR <= next_addr[AW-1:0];
                    next_addr <= next_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_data <= '0;
            fifo_last <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= '0;
        end else begin
            if (BRAM_EN) begin
                fifo_data[wr_ptr] <= BRAM_DO;
                fifo_last[wr_ptr] <= (BRAM_ADDR == LAST_A);
                wr_ptr            <= ~wr_ptr;
            end
            if (xfer) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, BRAM_EN} - {1'b0, xfer};
        end
    end

    assign W_VALID = (occ != 2'd0);
    assign W_DATA  = fifo_data[rd_ptr];
    assign W_LAST  = fifo_last[rd_ptr] && W_VALID;

`ifdef WEIGHT_READER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            CHECKSUM <= '0;
        else if (start_acc) CHECKSUM <= '0;
        else if (xfer)      CHECKSUM <= CHECKSUM + W_DATA;
    end
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Directed bench for weight_bram_reader: BRAM model with mem[i]=0x0100+i, checks
// timing, back-pressure, reset abort and (with WEIGHT_READER_CHECKSUM_EN) the checksum.
module tb_weight_bram_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  bram_addr;
    logic        bram_en, bram_we;
    logic [15:0] bram_do = 16'h0;
    logic [15:0] w_data;
    logic        w_valid, w_last, busy, done;
    logic        w_ready = 1'b0;
`ifdef WEIGHT_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    weight_bram_reader dut (
        .CLK(clk), .RST(rst), .START(start),
        .BRAM_ADDR(bram_addr), .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_DO(bram_do),
        .W_DATA(w_data), .W_VALID(w_valid), .W_READY(w_ready), .W_LAST(w_last),
        .BUSY(busy), .DONE(done)
`ifdef WEIGHT_READER_CHECKSUM_EN
       ,.CHECKSUM(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [32];
    always @(negedge clk) if (bram_en) bram_do <= mem[bram_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side occupancy model for the outstanding-read bound.
    int occ_m = 0;
    int max_out = 0;
    bit we_bad = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) occ_m = 0;
        else begin
            if (occ_m + int'(bram_en) > max_out) max_out = occ_m + int'(bram_en);
            occ_m = occ_m + int'(bram_en) - int'(w_valid && w_ready);
        end
    end
    always @(clk) if (bram_we !== 1'b0) we_bad = 1'b1;

    logic [15:0] got [64];
    int nw, nlast, last_pos, stall_err, done_cyc;
    logic [15:0] cs_c1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one pass; mode 0 = ready always high, mode 1 = ready alternating.
    task automatic run_pass(input int mode, input int start_pulse_cyc);
        bit prev_stall = 1'b0;
        logic [15:0] prev_data = 16'h0;
        bit r;
        int cyc = 1;
        nw = 0; nlast = 0; last_pos = -1; stall_err = 0; done_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef WEIGHT_READER_CHECKSUM_EN
        cs_c1 = checksum;
`else
        cs_c1 = 16'h0;
`endif
        while (cyc < 200) begin
            if (done) begin done_cyc = cyc; break; end
            if (prev_stall && (!w_valid || w_data !== prev_data)) stall_err++;
            r = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            w_ready = r;
            if (w_valid && r && nw < 64) begin
                got[nw] = w_data;
                if (w_last) begin nlast++; last_pos = nw; end
                nw++;
            end
            prev_stall = w_valid && !r;
            prev_data  = w_data;
            start = (cyc == start_pulse_cyc);
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bram_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", bram_addr); end
        n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%0h exp=0", bram_en); end
        n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0h exp=0", bram_we); end
        n_checks++; if (w_data !== 16'h0) begin n_fail++; $display("FAIL reset_wdata got=%0h exp=0", w_data); end
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", w_valid); end
        n_checks++; if (w_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%0h exp=0", w_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0h exp=0", done); end
`ifdef WEIGHT_READER_CHECKSUM_EN
        n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL reset_checksum got=%0h exp=0", checksum); end
`endif
        @(posedge clk);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        w_ready = 1'b1;
        max_out = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            if (c <= 30) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy c=%0d got=%0h exp=1", c, busy); end
            end
            if (c == 1) begin
                n_checks++; if (bram_en !== 1'b1) begin n_fail++; $display("FAIL stream_en1 got=%0h exp=1", bram_en); end
                n_checks++; if (bram_addr !== 5'd0) begin n_fail++; $display("FAIL stream_addr1 got=%0h exp=0", bram_addr); end
                n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid1 got=%0h exp=0", w_valid); end
            end
            if (c >= 2 && c <= 29) begin
                n_checks++; if (w_valid !== 1'b1 || w_data !== 16'h0100 + 16'(c-2))
                    begin n_fail++; $display("FAIL stream_word c=%0d got=%0h/%0h exp=1/%0h", c, w_valid, w_data, 16'h0100 + 16'(c-2)); end
                n_checks++; if (w_last !== (c == 29)) begin n_fail++; $display("FAIL stream_last c=%0d got=%0h exp=%0h", c, w_last, (c == 29)); end
            end
            if (c == 30) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stream_done got=%0h exp=1", done); end
                n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid30 got=%0h exp=0", w_valid); end
`ifdef WEIGHT_READER_CHECKSUM_EN
                n_checks++; if (checksum !== 16'h1D7A) begin n_fail++; $display("FAIL stream_checksum got=%0h exp=1d7a", checksum); end
`endif
            end
            if (c == 31) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy31 got=%0h exp=0 (START in DONE ignored)", busy); end
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stream_done31 got=%0h exp=0", done); end
`ifdef WEIGHT_READER_CHECKSUM_EN
                n_checks++; if (checksum !== 16'h1D7A) begin n_fail++; $display("FAIL stream_checksum_hold got=%0h exp=1d7a", checksum); end
`endif
            end
            start = (c == 30);
            tick();
        end
        start = 1'b0;
        n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL stream_outstanding got=%0d exp<=2", max_out); end
    endtask

    task automatic test_alternating();
        max_out = 0;
        run_pass(1, 0);
`ifdef WEIGHT_READER_CHECKSUM_EN
        n_checks++; if (cs_c1 !== 16'h0) begin n_fail++; $display("FAIL alt_checksum_clear got=%0h exp=0", cs_c1); end
`endif
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL alt_done got=timeout exp=DONE pulse"); end
        n_checks++; if (nw !== 28) begin n_fail++; $display("FAIL alt_count got=%0d exp=28", nw); end
        for (int k = 0; k < 28 && k < nw; k++) begin
            n_checks++; if (got[k] !== 16'h0100 + 16'(k)) begin n_fail++; $display("FAIL alt_word k=%0d got=%0h exp=%0h", k, got[k], 16'h0100 + 16'(k)); end
        end
        n_checks++; if (nlast !== 1 || last_pos !== 27) begin n_fail++; $display("FAIL alt_last got=%0d@%0d exp=1@27", nlast, last_pos); end
        n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL alt_stable got=%0d exp=0", stall_err); end
        n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL alt_outstanding got=%0d exp<=2", max_out); end
        tick();
    endtask

    task automatic test_back_pressure();
        int en_cnt = 0;
        int c = 1;
        int n;
        w_ready = 1'b0;
        max_out = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!w_valid && c < 20) begin en_cnt += int'(bram_en); tick(); c++; end
        n_checks++; if (w_valid !== 1'b1 || w_data !== 16'h0100) begin n_fail++; $display("FAIL bp_first got=%0h/%0h exp=1/100", w_valid, w_data); end
        repeat (10) begin en_cnt += int'(bram_en); tick(); c++; end
        n_checks++; if (en_cnt !== 2) begin n_fail++; $display("FAIL bp_reads got=%0d exp=2", en_cnt); end
        n_checks++; if (w_data !== 16'h0100) begin n_fail++; $display("FAIL bp_hold got=%0h exp=100", w_data); end
        w_ready = 1'b1;
        tick(); c++;
        n_checks++; if (w_valid !== 1'b1 || w_data !== 16'h0101) begin n_fail++; $display("FAIL bp_next got=%0h/%0h exp=1/101", w_valid, w_data); end
        n_checks++; if (bram_en !== 1'b1 || bram_addr !== 5'd2) begin n_fail++; $display("FAIL bp_resume got=%0h/%0h exp=1/2", bram_en, bram_addr); end
        n = 1;
        while (!done && c < 200) begin
            if (w_valid) begin
                n_checks++; if (w_data !== 16'h0100 + 16'(n)) begin n_fail++; $display("FAIL bp_word n=%0d got=%0h exp=%0h", n, w_data, 16'h0100 + 16'(n)); end
                n++;
            end
            tick(); c++;
        end
        n_checks++; if (done !== 1'b1 || n !== 28) begin n_fail++; $display("FAIL bp_end got=done%0h/%0d exp=done1/28", done, n); end
        n_checks++; if (max_out !== 2) begin n_fail++; $display("FAIL bp_outstanding got=%0d exp=2", max_out); end
        tick();
    endtask

    task automatic test_reset_midpass();
        w_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        n_checks++; if (w_data !== 16'h010A) begin n_fail++; $display("FAIL mid_word10 got=%0h exp=10a", w_data); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (w_valid !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0 || w_data !== 16'h0)
            begin n_fail++; $display("FAIL mid_abort got=v%0h b%0h e%0h d%0h exp=all 0", w_valid, busy, bram_en, w_data); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_pass(0, 5);
        n_checks++; if (done_cyc !== 30) begin n_fail++; $display("FAIL mid_done got=%0d exp=30", done_cyc); end
        n_checks++; if (nw !== 28) begin n_fail++; $display("FAIL mid_count got=%0d exp=28", nw); end
        for (int k = 0; k < 28 && k < nw; k++) begin
            n_checks++; if (got[k] !== 16'h0100 + 16'(k)) begin n_fail++; $display("FAIL mid_word k=%0d got=%0h exp=%0h", k, got[k], 16'h0100 + 16'(k)); end
        end
        n_checks++; if (nlast !== 1 || last_pos !== 27) begin n_fail++; $display("FAIL mid_last got=%0d@%0d exp=1@27", nlast, last_pos); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
        test_reset();
        test_stream();
        test_alternating();
        test_back_pressure();
        test_reset_midpass();
        n_checks++; if (we_bad !== 1'b0) begin n_fail++; $display("FAIL bram_we got=1 exp=0"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
